// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch PC unit.
//   fetch_state_e    - request tracking state (IDLE / WAIT / DROP)
//   PC_INCR          - sequential PC step in bytes
//   DEFAULT_RESET_PC - default reset PC
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // free to issue a request
        WAIT = 2'd1,   // one request outstanding, response wanted
        DROP = 2'd2    // one request outstanding, response is stale
    } fetch_state_e;

    localparam int unsigned PC_INCR          = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry {instr, pc} holding register behind the decode slot.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   load_i       - capture instr_i/pc_i and mark valid
//   pop_i        - entry consumed, mark empty
//   clear_i      - squash entry (dominates load/pop)
//   instr_i/pc_i - entry to capture
//   valid_o      - entry held
//   instr_o/pc_o - held entry
module fetch_skid_buf #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               pop_i,
    input  logic               clear_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o
);

    logic               valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  pc_q;

    // Entry register; clear wins, then load, then pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end else if (pop_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: owns the architectural PC, issues one instruction-memory
// request at a time and presents {instr, pc, pc+4} to decode (valid/ready).
// Redirects squash the in-flight fetch, the decode slot and the skid entry.
// Optional build macro FETCH_ALIGN_CHECK_EN adds fetch_misalign: a redirect to
// a non word-aligned target raises it and blocks requests until an aligned
// redirect (or rst).
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   redirect_valid/addr          - taken jump/branch and its target
//   imem_req_valid/ready, addr   - memory request (valid is combinational)
//   imem_rsp_valid/data          - memory response, never back-pressured
//   if_valid/ready               - decode slot handshake
//   if_instr, if_pc, if_pc_plus4 - decode slot payload
//   fetch_misalign               - misaligned redirect flag (macro only)
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic               fetch_misalign,
`endif
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pc_plus4
);

    localparam logic [ADDR_W-1:0] INCR = ADDR_W'(PC_INCR);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
    logic               out_valid_q, out_valid_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d;
    logic [ADDR_W-1:0]  out_pc_q, out_pc_d;

    logic               skid_valid;
    logic [INSTR_W-1:0] skid_instr;
    logic [ADDR_W-1:0]  skid_pc;
    logic               skid_load, skid_pop, skid_clear;

    logic               req_block;
    logic               req_fire;
    logic               rsp_take;
    logic               drain;

`ifdef FETCH_ALIGN_CHECK_EN
    logic               misalign_q, misalign_d;
    assign req_block      = misalign_q;
    assign fetch_misalign = misalign_q;
`else
    assign req_block      = 1'b0;
`endif

    // Request only when nothing is outstanding and the skid can absorb the result.
    assign imem_req_valid = (state_q == IDLE) && !skid_valid && !redirect_valid
                            && !rst && !req_block;
    assign imem_addr      = pc_q;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_take = (state_q == WAIT) && imem_rsp_valid && !redirect_valid;
    assign drain    = out_valid_q && if_ready;

    // Next-state, PC and decode-slot control.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        skid_load   = 1'b0;
        skid_pop    = 1'b0;
        skid_clear  = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        misalign_d  = misalign_q;
`endif

        // Any response ends the outstanding request, wanted or stale.
        case (state_q)
            IDLE: if (req_fire) state_d = WAIT;
            WAIT: begin
                if (imem_rsp_valid)      state_d = IDLE;
                else if (redirect_valid) state_d = DROP;
            end
            DROP: if (imem_rsp_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (req_fire) begin
            pc_d     = pc_q + INCR;
            req_pc_d = pc_q;
        end

        if (drain) out_valid_d = 1'b0;

        // Skid is always empty while a request is outstanding, so a response
        // and a skid pop never coincide.
        if (rsp_take) begin
            if (!out_valid_q || drain) begin
                out_valid_d = 1'b1;
                out_instr_d = imem_rsp_data;
                out_pc_d    = req_pc_q;
            end else begin
                skid_load   = 1'b1;
            end
        end else if (drain && skid_valid) begin
            out_valid_d = 1'b1;
            out_instr_d = skid_instr;
            out_pc_d    = skid_pc;
            skid_pop    = 1'b1;
        end

        if (redirect_valid) begin
            pc_d        = redirect_addr;
            out_valid_d = 1'b0;
            skid_clear  = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_d  = |redirect_addr[1:0];
`endif
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

    fetch_skid_buf #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .pop_i   (skid_pop),
        .clear_i (skid_clear),
        .instr_i (imem_rsp_data),
        .pc_i    (req_pc_q),
        .valid_o (skid_valid),
        .instr_o (skid_instr),
        .pc_o    (skid_pc)
    );

    assign if_valid    = out_valid_q;
    assign if_instr    = out_instr_q;
    assign if_pc       = out_pc_q;
    assign if_pc_plus4 = out_pc_q + INCR;

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch stage that owns the architectural PC and directly feeds the decode/jump stage.
- Issues one instruction-memory request at a time and presents {instr, pc, pc+4} to decode through a valid/ready interface.
- Consumes redirect_valid/redirect_addr, driven from the jump unit's jump_taken/jump_address. On a redirect it squashes in-flight and buffered fetches.

Parameters:
- ADDR_W, 32, PC/address width.
- INSTR_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- redirect_valid  input  1  jump/branch taken this cycle.
- redirect_addr  input  ADDR_W  new PC target.
- imem_req_valid  output  1  request to instruction memory.
- imem_req_ready  input  1  memory accepts request.
- imem_addr  output  ADDR_W  request address (= pc).
- imem_rsp_valid  input  1  response data valid; no back-pressure, must be accepted.
- imem_rsp_data  input  INSTR_W  fetched instruction.
- if_valid  output  1  decode slot holds a valid instruction.
- if_ready  input  1  decode consumes the slot this cycle.
- if_instr  output  INSTR_W  instruction to decode.
- if_pc  output  ADDR_W  address of if_instr.
- if_pc_plus4  output  ADDR_W  if_pc+4, the link address source.

Behaviour:
- Reset (sync, rst=1 at edge):
  - pc=RESET_PC, state=IDLE, skid empty.
  - if_valid=0, if_instr=0, if_pc=0.
  - imem_req_valid=0 during the reset cycle.
- States:
  - IDLE: may issue a request.
  - WAIT: one request outstanding.
  - DROP: outstanding request is stale; its response is discarded.
- Request generation:
  - imem_req_valid = (state==IDLE) && skid empty && !redirect_valid && !rst.
  - imem_addr = pc.
  - Combinational: valid may deassert before acceptance; memory must tolerate withdrawal.
- Handshake in IDLE (valid && ready): pc <= pc+4, req_pc <= pc, go WAIT. At most one outstanding request.
- imem_rsp_valid in WAIT: go IDLE.
  - If output slot is empty, or drained this cycle (if_valid && if_ready): load if_instr/if_pc from rsp_data/req_pc, if_valid=1.
  - Otherwise: load the one-entry skid buffer.
- Drain: when the output drains and the skid is full, skid moves to output the same cycle and the skid empties.
- Output stability: if_valid, if_instr and if_pc are stable while if_valid && !if_ready.
- Response-state rules:
  - imem_rsp_valid in IDLE is ignored. This covers stale responses after reset.
  - imem_rsp_valid in DROP is discarded; go IDLE.
- Redirect (highest priority after rst), in any state:
  - pc <= redirect_addr; if_valid <= 0; skid cleared.
  - WAIT goes to DROP, and DROP stays DROP.
  - IDLE stays IDLE; no request is issued that cycle.
- Simultaneous events:
  - Redirect with rsp_valid in WAIT: response discarded, go IDLE, pc = redirect_addr.
  - Redirect with if_ready: slot cleared regardless.
- Arithmetic:
  - pc+4 and if_pc_plus4 wrap modulo 2^ADDR_W (FFFF_FFFC+4 = 0).
  - redirect_addr is taken as-is.
- Latency: minimum 2 cycles from request acceptance to if_valid, for a memory that responds one cycle after accept.
- Throughput: one instruction per 2 cycles. Pipelined fetch is out of scope.

Optional Feature:
- Macro FETCH_ALIGN_CHECK_EN.
- With it:
  - Added output fetch_misalign (1 bit, reset 0).
  - A redirect with redirect_addr[1:0]!=0 sets fetch_misalign=1, loads pc, and blocks all requests until the next redirect with aligned address or rst. The aligned redirect clears the flag.
- Without it: no port, no check; misaligned addresses are fetched unmodified.

Decomposition:
- Shared package fetch_pkg:
  - state enum {IDLE, WAIT, DROP};
  - constant PC_INCR=4;
  - default RESET_PC.
- One sub-module, fetch_skid_buf: one-entry {instr, pc} holding register with valid, load, pop and clear inputs.

Test Plan:
- Reset with RESET_PC=0x0000_0040, memory accepts immediately and responds next cycle -> imem_addr sequence 0x40, 0x44, 0x48. if_pc matches, if_pc_plus4=0x44 for the first instruction.
- if_ready held 0 for 6 cycles after the first instruction -> exactly one further request issued (into skid). No further request until drain. Order is preserved on release: if_pc 0x40 then 0x44.
- redirect_valid=1, redirect_addr=0x0000_1000 while in WAIT -> the next response is discarded. if_valid=0 until the fetch of 0x1000 returns. No instruction from the old path reaches decode.
- redirect asserted in the same cycle as imem_rsp_valid, with skid full -> both output and skid cleared, state IDLE. Next imem_addr=redirect_addr.
- pc=0xFFFF_FFFC fetched -> next imem_addr=0x0000_0000, if_pc_plus4=0x0000_0000.
- With FETCH_ALIGN_CHECK_EN, redirect_addr=0x0000_1002 -> fetch_misalign=1, imem_req_valid stays 0. Then redirect to 0x2000 -> flag clears, imem_addr=0x2000.
